// File: rtl/nvme_pkg.sv
// Shared NVMe host-buffer definitions: address map, AXI encodings and the
// completion-queue entry layout.
package nvme_pkg;

    localparam int unsigned OUTSTANDING    = 1;
    localparam logic [31:0] WRITE_BUF_BASE = 32'h0000_0000;
    localparam logic [31:0] READ_BUF_BASE  = 32'h0001_0000;
    localparam logic [31:0] SQ_BASE        = 32'h0002_0000;
    localparam logic [31:0] CQ_BASE        = 32'h0002_0400;

    localparam logic [2:0]  BEAT_SIZE  = 3'd4;
    localparam int unsigned PHASE_BYTE = 14;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [14:0] status;
        logic        phase;
        logic [15:0] cid;
        logic [15:0] sqid;
        logic [15:0] sqhd;
        logic [31:0] dw1;
        logic [31:0] dw0;
    } cq_entry_t;

endpackage

// File: rtl/nvme_cq_regfile.sv
// CQ entry storage: byte-enabled write port and a registered read port that
// returns the pre-write contents when both hit the same entry in one cycle.
module nvme_cq_regfile #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned IDXW       = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [IDXW-1:0]           waddr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
    input  logic                      re_i,
    input  logic [IDXW-1:0]           raddr_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);
    import nvme_pkg::*;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
            if (we_i) begin
                for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
                    if (wstrb_i[b]) begin
                        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nvme_cq_ring.sv
// Host-side NVMe completion queue: AXI write slave for CQ entries plus a
// single-beat polling read port. NVME_CQ_RING_IRQ_EN enables the cq_irq pulse.
module nvme_cq_ring #(
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 128,
    parameter logic [31:0] CQ_BASE       = 32'h0002_0400,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned CQ_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ID_WIDTH-1:0]        ns_awid,
    input  logic [ADDR_WIDTH-1:0]      ns_awaddr,
    input  logic [7:0]                 ns_awlen,
    input  logic [2:0]                 ns_awsize,
    input  logic [1:0]                 ns_awburst,
    input  logic                       ns_awvalid,
    output logic                       ns_awready,
    input  logic [DATA_WIDTH-1:0]      ns_wdata,
    input  logic [DATA_WIDTH/8-1:0]    ns_wstrb,
    input  logic                       ns_wlast,
    input  logic                       ns_wvalid,
    output logic                       ns_wready,
    output logic [ID_WIDTH-1:0]        ns_bid,
    output logic [1:0]                 ns_bresp,
    output logic                       ns_bvalid,
    input  logic                       ns_bready,
    input  logic [CQ_ADDR_WIDTH-1:0]   cq_araddr,
    input  logic [7:0]                 cq_arlen,
    input  logic [2:0]                 cq_arsize,
    input  logic [1:0]                 cq_arburst,
    input  logic                       cq_arvalid,
    output logic                       cq_arready,
    output logic [DATA_WIDTH-1:0]      cq_rdata,
    output logic [1:0]                 cq_rresp,
    output logic                       cq_rlast,
    output logic                       cq_rvalid,
    input  logic                       cq_rready,
    output logic                       cq_irq
);
    import nvme_pkg::*;

    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WIN_LO = ADDR_WIDTH'(CQ_BASE);
    localparam logic [ADDR_WIDTH-1:0] WIN_HI = WIN_LO + ADDR_WIDTH'(DEPTH * 16);

    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
    typedef enum logic {RIdle, RValid} rstate_e;

    wstate_e                 wstate_q;
    logic [ID_WIDTH-1:0]     awid_q, bid_q;
    logic [ADDR_WIDTH-1:0]   addr_q, wr_off;
    logic [7:0]              len_q, cnt_q;
    logic                    past_q, err_q;
    logic                    awready_q, wready_q, bvalid_q;
    logic [1:0]              bresp_q;
    logic                    aw_fire, w_fire, in_win, exp_last, beat_err, wr_en;
    logic [IDXW-1:0]         wr_idx, rd_idx;

    rstate_e                 rstate_q;
    logic                    rerr_q, rvalid, ar_fire;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    unused_arburst;

    always_comb begin
        aw_fire  = ns_awvalid & awready_q;
        w_fire   = ns_wvalid & wready_q;
        in_win   = (addr_q >= WIN_LO) && (addr_q < WIN_HI);
        exp_last = (cnt_q == len_q) && !past_q;
        beat_err = !in_win || (ns_wlast != exp_last);
        // past_q marks beats beyond awlen that keep arriving until wlast
        wr_en    = w_fire && in_win && !past_q;
        wr_off   = addr_q - WIN_LO;
        wr_idx   = IDXW'(wr_off >> 4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q  <= WIdle;
            awid_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            past_q    <= 1'b0;
            err_q     <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            bid_q     <= '0;
        end else begin
            unique case (wstate_q)
                WIdle: begin
                    if (aw_fire) begin
                        awid_q    <= ns_awid;
                        addr_q    <= ns_awaddr;
                        len_q     <= ns_awlen;
                        cnt_q     <= '0;
                        past_q    <= 1'b0;
                        err_q     <= (ns_awsize != BEAT_SIZE) || (ns_awburst != BurstIncr);
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= WData;
                    end
                end
                WData: begin
                    if (w_fire) begin
                        addr_q <= addr_q + ADDR_WIDTH'(16);
                        if (cnt_q == len_q) begin
                            past_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                        if (beat_err) begin
                            err_q <= 1'b1;
                        end
                        if (ns_wlast) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err_q || beat_err) ? RespSlverr : RespOkay;
                            bid_q    <= awid_q;
                            wstate_q <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (ns_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= WIdle;
                    end
                end
                default: wstate_q <= WIdle;
            endcase
        end
    end

    assign ns_awready = awready_q;
    assign ns_wready  = wready_q;
    assign ns_bvalid  = bvalid_q;
    assign ns_bresp   = bresp_q;
    assign ns_bid     = bid_q;

    assign rvalid     = (rstate_q == RValid);
    assign cq_arready = ~rvalid | cq_rready;
    assign ar_fire    = cq_arvalid & cq_arready;
    assign rd_idx     = IDXW'(cq_araddr >> 4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q <= RIdle;
            rerr_q   <= 1'b0;
        end else if (ar_fire) begin
            rstate_q <= RValid;
            rerr_q   <= (cq_arlen != 8'd0) || (cq_arsize != BEAT_SIZE);
        end else if (cq_rready) begin
            rstate_q <= RIdle;
        end
    end

    assign cq_rvalid = rvalid;
    assign cq_rlast  = rvalid;
    assign cq_rresp  = rerr_q ? RespSlverr : RespOkay;
    assign cq_rdata  = rerr_q ? '0 : rd_data;

    assign unused_arburst = ^cq_arburst;

    nvme_cq_regfile #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDXW       (IDXW)
    ) u_regfile (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_en),
        .waddr_i (wr_idx),
        .wdata_i (ns_wdata),
        .wstrb_i (ns_wstrb),
        .re_i    (ar_fire),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

`ifdef NVME_CQ_RING_IRQ_EN
    logic phase_wr_q, irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_wr_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (aw_fire) begin
                phase_wr_q <= 1'b0;
            end else if (wr_en && ns_wstrb[PHASE_BYTE]) begin
                phase_wr_q <= 1'b1;
            end
            irq_q <= bvalid_q && ns_bready && (bresp_q == RespOkay) && phase_wr_q;
        end
    end

    assign cq_irq = irq_q;
`else
    assign cq_irq = 1'b0;
`endif

endmodule

// File: tb/tb_nvme_cq_ring.sv
// Scoreboard bench for nvme_cq_ring: B and R expectations are queued as stimulus
// is driven and checked when the DUT responds.
module tb_nvme_cq_ring;
    import nvme_pkg::*;

    localparam logic [31:0] BASE = 32'h0002_0400;
    localparam int MAXW = 50;
`ifdef NVME_CQ_RING_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   ns_awid = '0;
    logic [31:0]  ns_awaddr = '0;
    logic [7:0]   ns_awlen = '0;
    logic [2:0]   ns_awsize = '0;
    logic [1:0]   ns_awburst = '0;
    logic         ns_awvalid = 1'b0;
    logic         ns_awready;
    logic [127:0] ns_wdata = '0;
    logic [15:0]  ns_wstrb = '0;
    logic         ns_wlast = 1'b0;
    logic         ns_wvalid = 1'b0;
    logic         ns_wready;
    logic [3:0]   ns_bid;
    logic [1:0]   ns_bresp;
    logic         ns_bvalid;
    logic         ns_bready = 1'b0;
    logic [7:0]   cq_araddr = '0;
    logic [7:0]   cq_arlen = '0;
    logic [2:0]   cq_arsize = '0;
    logic [1:0]   cq_arburst = '0;
    logic         cq_arvalid = 1'b0;
    logic         cq_arready;
    logic [127:0] cq_rdata;
    logic [1:0]   cq_rresp;
    logic         cq_rlast;
    logic         cq_rvalid;
    logic         cq_rready = 1'b0;
    logic         cq_irq;

    nvme_cq_ring dut (
        .clk        (clk),
        .rst        (rst),
        .ns_awid    (ns_awid),
        .ns_awaddr  (ns_awaddr),
        .ns_awlen   (ns_awlen),
        .ns_awsize  (ns_awsize),
        .ns_awburst (ns_awburst),
        .ns_awvalid (ns_awvalid),
        .ns_awready (ns_awready),
        .ns_wdata   (ns_wdata),
        .ns_wstrb   (ns_wstrb),
        .ns_wlast   (ns_wlast),
        .ns_wvalid  (ns_wvalid),
        .ns_wready  (ns_wready),
        .ns_bid     (ns_bid),
        .ns_bresp   (ns_bresp),
        .ns_bvalid  (ns_bvalid),
        .ns_bready  (ns_bready),
        .cq_araddr  (cq_araddr),
        .cq_arlen   (cq_arlen),
        .cq_arsize  (cq_arsize),
        .cq_arburst (cq_arburst),
        .cq_arvalid (cq_arvalid),
        .cq_arready (cq_arready),
        .cq_rdata   (cq_rdata),
        .cq_rresp   (cq_rresp),
        .cq_rlast   (cq_rlast),
        .cq_rvalid  (cq_rvalid),
        .cq_rready  (cq_rready),
        .cq_irq     (cq_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic       irq;
    } bexp_t;

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   resp;
    } rexp_t;

    int           total = 0;
    int           bad = 0;
    logic [127:0] mdl [16];
    bexp_t        bq [$];
    rexp_t        rq [$];
    logic [31:0]  cur_addr;
    logic [7:0]   cur_len, cur_cnt;
    logic [3:0]   cur_id;
    bit           cur_err, cur_past, cur_phase;

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        ns_awvalid = 1'b1; ns_awid = id; ns_awaddr = addr;
        ns_awlen = len; ns_awsize = size; ns_awburst = burst;
        #1;
        while (!ns_awready && n < MAXW) begin @(negedge clk); #1; n++; end
        total++;
        if (ns_awready !== 1'b1) begin
            bad++; $display("FAIL aw_timeout: awready=%b want 1", ns_awready);
        end
        @(posedge clk); #1;
        ns_awvalid = 1'b0;
        cur_id = id; cur_addr = addr; cur_len = len; cur_cnt = '0;
        cur_past = 1'b0; cur_phase = 1'b0;
        cur_err = (size != 3'd4) || (burst != 2'b01);
    endtask

    // Optionally issues a read in the same cycle to exercise the collision case.
    task automatic w_beat(input logic [127:0] data, input logic [15:0] strb, input logic last,
                          input bit with_ar, input logic [7:0] ar_addr);
        int n = 0;
        int idx;
        bit in_win, exp_last;
        @(negedge clk);
        ns_wvalid = 1'b1; ns_wdata = data; ns_wstrb = strb; ns_wlast = last;
        if (with_ar) begin
            cq_arvalid = 1'b1; cq_araddr = ar_addr; cq_arlen = 8'd0; cq_arsize = 3'd4;
        end
        #1;
        while (!ns_wready && n < MAXW) begin @(negedge clk); #1; n++; end
        total++;
        if (ns_wready !== 1'b1) begin
            bad++; $display("FAIL w_timeout: wready=%b want 1", ns_wready);
        end
        if (with_ar) begin
            total++;
            if (cq_arready !== 1'b1) begin
                bad++; $display("FAIL collide_arready: got %b want 1", cq_arready);
            end
            rq.push_back('{data: mdl[ar_addr[7:4]], resp: 2'b00});
        end
        @(posedge clk); #1;
        ns_wvalid = 1'b0; ns_wlast = 1'b0; cq_arvalid = 1'b0;
        in_win = (cur_addr >= BASE) && (cur_addr < BASE + 32'd256);
        exp_last = (cur_cnt == cur_len) && !cur_past;
        if (in_win && !cur_past) begin
            idx = int'((cur_addr - BASE) >> 4);
            for (int b = 0; b < 16; b++) begin
                if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
            end
            if (strb[14]) cur_phase = 1'b1;
        end
        if (!in_win || (last != exp_last)) cur_err = 1'b1;
        if (cur_cnt == cur_len) cur_past = 1'b1;
        else cur_cnt = cur_cnt + 8'd1;
        cur_addr = cur_addr + 32'd16;
        if (last) begin
            bq.push_back('{id: cur_id, resp: cur_err ? 2'b10 : 2'b00,
                           irq: IRQ_ON && !cur_err && cur_phase});
        end
    endtask

    task automatic b_recv(input int delay);
        int n = 0;
        bexp_t e;
        if (bq.size() == 0) begin
            total++; bad++; $display("FAIL b_queue: got empty want entry");
            return;
        end
        e = bq.pop_front();
        @(negedge clk); #1;
        while (!ns_bvalid && n < MAXW) begin @(negedge clk); #1; n++; end
        total++;
        if (ns_bvalid !== 1'b1) begin
            bad++; $display("FAIL b_timeout: bvalid=%b want 1", ns_bvalid);
        end
        for (int i = 0; i < delay; i++) begin
            total++;
            if (ns_awready !== 1'b0 || ns_bvalid !== 1'b1) begin
                bad++;
                $display("FAIL b_hold: awready=%b bvalid=%b want 0 1", ns_awready, ns_bvalid);
            end
            @(negedge clk); #1;
        end
        ns_bready = 1'b1;
        total++;
        if (ns_bid !== e.id) begin
            bad++; $display("FAIL bid: got %h want %h", ns_bid, e.id);
        end
        total++;
        if (ns_bresp !== e.resp) begin
            bad++; $display("FAIL bresp: got %b want %b", ns_bresp, e.resp);
        end
        @(posedge clk); #1;
        ns_bready = 1'b0;
        @(negedge clk); #1;
        total++;
        if (cq_irq !== e.irq) begin
            bad++; $display("FAIL irq_pulse: got %b want %b", cq_irq, e.irq);
        end
        total++;
        if (ns_awready !== 1'b1 || ns_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL b_release: awready=%b bvalid=%b want 1 0", ns_awready, ns_bvalid);
        end
        @(negedge clk); #1;
        total++;
        if (cq_irq !== 1'b0) begin
            bad++; $display("FAIL irq_width: got %b want 0", cq_irq);
        end
    endtask

    task automatic ar_send(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size);
        int n = 0;
        bit err;
        @(negedge clk);
        cq_arvalid = 1'b1; cq_araddr = addr; cq_arlen = len; cq_arsize = size;
        #1;
        while (!cq_arready && n < MAXW) begin @(negedge clk); #1; n++; end
        total++;
        if (cq_arready !== 1'b1) begin
            bad++; $display("FAIL ar_timeout: arready=%b want 1", cq_arready);
        end
        err = (len != 8'd0) || (size != 3'd4);
        rq.push_back('{data: err ? 128'd0 : mdl[addr[7:4]], resp: err ? 2'b10 : 2'b00});
        @(posedge clk); #1;
        cq_arvalid = 1'b0;
    endtask

    task automatic r_recv(input int hold);
        int n = 0;
        rexp_t e;
        if (rq.size() == 0) begin
            total++; bad++; $display("FAIL r_queue: got empty want entry");
            return;
        end
        e = rq.pop_front();
        @(negedge clk); #1;
        while (!cq_rvalid && n < MAXW) begin @(negedge clk); #1; n++; end
        total++;
        if (cq_rvalid !== 1'b1) begin
            bad++; $display("FAIL r_timeout: rvalid=%b want 1", cq_rvalid);
        end
        for (int i = 0; i < hold; i++) begin
            total++;
            if (cq_rvalid !== 1'b1 || cq_rdata !== e.data || cq_arready !== 1'b0) begin
                bad++;
                $display("FAIL r_hold: rvalid=%b arready=%b rdata=%h want 1 0 %h",
                         cq_rvalid, cq_arready, cq_rdata, e.data);
            end
            @(negedge clk); #1;
        end
        cq_rready = 1'b1;
        #1;
        total++;
        if (cq_rdata !== e.data) begin
            bad++; $display("FAIL rdata: got %h want %h", cq_rdata, e.data);
        end
        total++;
        if (cq_rresp !== e.resp || cq_rlast !== 1'b1) begin
            bad++;
            $display("FAIL rresp_rlast: got %b %b want %b 1", cq_rresp, cq_rlast, e.resp);
        end
        @(posedge clk); #1;
        cq_rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] got;
        logic [14:0] want;
        want = 15'b1_0_0_00_0000_1_0_00_0_0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        got = {ns_awready, ns_wready, ns_bvalid, ns_bresp, ns_bid,
               cq_arready, cq_rvalid, cq_rresp, cq_rlast, cq_irq};
        total++;
        if (got !== want) begin
            bad++; $display("FAIL reset_outputs: got %b want %b", got, want);
        end
        total++;
        if (cq_rdata !== 128'd0) begin
            bad++; $display("FAIL reset_rdata: got %h want 0", cq_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        ar_send(8'h00, 8'd0, 3'd4); r_recv(0);
        ar_send(8'hF0, 8'd0, 3'd4); r_recv(0);
    endtask

    task automatic test_single_write();
        cq_entry_t e;
        e = '0;
        e.phase = 1'b1; e.cid = 16'd3; e.dw0 = 32'hDEAD_BEEF; e.sqhd = 16'd7; e.sqid = 16'd1;
        aw_send(4'h5, BASE, 8'd0, 3'd4, 2'b01);
        w_beat(e, 16'hFFFF, 1'b1, 1'b0, 8'h00);
        b_recv(0);
        ar_send(8'h00, 8'd0, 3'd4); r_recv(0);
    endtask

    task automatic test_burst();
        aw_send(4'hA, BASE + 32'hF0, 8'd1, 3'd4, 2'b01);
        w_beat({8{16'hC0DE}}, 16'hFFFF, 1'b0, 1'b0, 8'h00);
        w_beat({8{16'hBAD0}}, 16'hFFFF, 1'b1, 1'b0, 8'h00);
        b_recv(0);
        ar_send(8'hF0, 8'd0, 3'd4); r_recv(0);
        ar_send(8'h00, 8'd0, 3'd4); r_recv(0);
    endtask

    task automatic test_strobe();
        logic [127:0] d;
        d = {16{8'hAA}};
        d[119:112] = 8'h01;
        aw_send(4'h3, BASE + 32'h50, 8'd0, 3'd4, 2'b01);
        w_beat(d, 16'h4000, 1'b1, 1'b0, 8'h00);
        b_recv(0);
        ar_send(8'h5C, 8'd0, 3'd4); r_recv(0);
    endtask

    task automatic test_collision();
        aw_send(4'h2, BASE + 32'h20, 8'd0, 3'd4, 2'b01);
        w_beat({4{32'h1234_5678}}, 16'hFFFF, 1'b1, 1'b1, 8'h20);
        b_recv(0);
        r_recv(0);
        ar_send(8'h20, 8'd0, 3'd4); r_recv(0);
    endtask

    task automatic test_backpressure();
        aw_send(4'h9, BASE + 32'h30, 8'd0, 3'd4, 2'b01);
        w_beat({4{32'h0BAD_F00D}}, 16'h0FFF, 1'b1, 1'b0, 8'h00);
        b_recv(3);
        ar_send(8'h30, 8'd0, 3'd4); r_recv(5);
    endtask

    task automatic test_errors();
        ar_send(8'h00, 8'd1, 3'd4); r_recv(0);
        ar_send(8'h00, 8'd0, 3'd3); r_recv(0);
        aw_send(4'h1, 32'h0002_0000, 8'd0, 3'd4, 2'b01);
        w_beat({4{32'h5555_AAAA}}, 16'hFFFF, 1'b1, 1'b0, 8'h00);
        b_recv(0);
        aw_send(4'h7, BASE + 32'h70, 8'd2, 3'd4, 2'b01);
        w_beat({4{32'h7777_0007}}, 16'hFFFF, 1'b1, 1'b0, 8'h00);
        b_recv(0);
        aw_send(4'h8, BASE + 32'h80, 8'd0, 3'd4, 2'b01);
        w_beat({4{32'h8888_0008}}, 16'hFFFF, 1'b0, 1'b0, 8'h00);
        w_beat({4{32'h9999_0009}}, 16'hFFFF, 1'b1, 1'b0, 8'h00);
        b_recv(0);
        aw_send(4'hB, BASE + 32'hA0, 8'd0, 3'd3, 2'b01);
        w_beat({4{32'hAAAA_000A}}, 16'hFFFF, 1'b1, 1'b0, 8'h00);
        b_recv(0);
        aw_send(4'hC, BASE + 32'hB0, 8'd0, 3'd4, 2'b00);
        w_beat({4{32'hBBBB_000B}}, 16'hFFFF, 1'b1, 1'b0, 8'h00);
        b_recv(0);
        ar_send(8'h70, 8'd0, 3'd4); r_recv(0);
        ar_send(8'h80, 8'd0, 3'd4); r_recv(0);
        ar_send(8'h90, 8'd0, 3'd4); r_recv(0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [4];
        rexp_t e;
        addrs = '{8'h00, 8'hF0, 8'h50, 8'h20};
        cq_rready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                cq_arvalid = 1'b1; cq_araddr = addrs[i]; cq_arlen = 8'd0; cq_arsize = 3'd4;
            end else begin
                cq_arvalid = 1'b0;
            end
            #1;
            if (i < 4) begin
                total++;
                if (cq_arready !== 1'b1) begin
                    bad++; $display("FAIL b2b_arready: got %b want 1", cq_arready);
                end
                rq.push_back('{data: mdl[addrs[i][7:4]], resp: 2'b00});
            end
            if (i > 0) begin
                e = rq.pop_front();
                total++;
                if (cq_rvalid !== 1'b1 || cq_rdata !== e.data) begin
                    bad++;
                    $display("FAIL b2b_rdata: rvalid=%b rdata=%h want 1 %h",
                             cq_rvalid, cq_rdata, e.data);
                end
            end
        end
        @(posedge clk); #1;
        cq_rready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        aw_send(4'h6, BASE + 32'h60, 8'd3, 3'd4, 2'b01);
        w_beat({4{32'h6666_0006}}, 16'hFFFF, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            total++;
            if (ns_bvalid !== 1'b0 || ns_awready !== 1'b1 || ns_wready !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_state: bvalid=%b awready=%b wready=%b want 0 1 0",
                         ns_bvalid, ns_awready, ns_wready);
            end
        end
        for (int i = 0; i < 16; i++) begin
            ar_send(8'(i << 4), 8'd0, 3'd4);
            r_recv(0);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst();
        test_strobe();
        test_collision();
        test_backpressure();
        test_errors();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nvme_cq_ring.md
Name: nvme_cq_ring

Overview:
- Host-side completion-queue storage for the NVMe I/O path.
- Sits downstream of the NVMe controller's AXI master (ns_* slave port). Accepts 16 B completion-entry writes into a 16-entry CQ register file.
- Serves single-beat 16 B polling reads from the driver's cq_ar/cq_r port.
- Out-of-window writes are dropped with SLVERR.

Parameters:
- ID_WIDTH, 4, AXI ID width on the ns write port.
- ADDR_WIDTH, 32, ns write address width.
- DATA_WIDTH, 128, ns and cq data width; one CQ entry per beat.
- CQ_BASE, 32'h0002_0400, byte base of the CQ window (after 64 KB write buffer, 64 KB read buffer, 1 KB SQ).
- DEPTH, 16, CQ entries; power of two; window size DEPTH*16 B.
- CQ_ADDR_WIDTH, 8, cq_araddr width (byte offset inside the window).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ns_awid  in  ID_WIDTH  write ID
- ns_awaddr  in  ADDR_WIDTH  burst start byte address
- ns_awlen  in  8  beats-1
- ns_awsize  in  3  must be 4
- ns_awburst  in  2  must be 1 (INCR)
- ns_awvalid/ns_awready  in/out  1  AW handshake
- ns_wdata  in  DATA_WIDTH  entry data
- ns_wstrb  in  DATA_WIDTH/8  byte enables
- ns_wlast  in  1  last beat
- ns_wvalid/ns_wready  in/out  1  W handshake
- ns_bid  out  ID_WIDTH  echoed awid
- ns_bresp  out  2  OKAY/SLVERR
- ns_bvalid/ns_bready  out/in  1  B handshake
- cq_araddr  in  CQ_ADDR_WIDTH  entry byte offset; bits[3:0] ignored
- cq_arlen  in  8  must be 0
- cq_arsize  in  3  must be 4
- cq_arburst  in  2  ignored
- cq_arvalid/cq_arready  in/out  1  AR handshake
- cq_rdata  out  DATA_WIDTH  entry contents
- cq_rresp  out  2  OKAY/SLVERR
- cq_rlast  out  1  always 1 with rvalid
- cq_rvalid/cq_rready  out/in  1  R handshake
- cq_irq  out  1  completion pulse (see Optional Feature)

Behaviour:
- Reset (async, active-high): all entries = 0, so every phase tag (bit 112) is 0. Driver's initial expected phase is 1, so no stale entry is valid.
- Reset outputs: awready=1, wready=0, bvalid=0, bresp=0, bid=0, arready=1, rvalid=0, rdata=0, rresp=0, rlast=0, cq_irq=0.
- Reset mid-burst aborts the burst; no B response is issued.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. One burst outstanding; no AW/W interleave.
  - W_IDLE: awready=1, wready=0. On AW handshake latch id, len, beat address, err = (awsize!=4 or awburst!=1); go to W_DATA.
  - W_DATA: awready=0, wready=1. Each beat is in-window iff CQ_BASE <= addr < CQ_BASE+DEPTH*16.
    - In-window beats write bytes selected by wstrb into entry (addr-CQ_BASE)>>4.
    - Out-of-window beats are dropped and set err.
    - Beat address += 16, no wrap.
    - wlast early or late vs awlen sets err. The burst ends at the wlast beat; beats past awlen are dropped.
  - W_RESP: bvalid=1, bresp = err ? 2'b10 : 2'b00, bid = latched id. Hold until bready, then W_IDLE.
  - Throughput: AW-to-first-W one cycle; last-W-to-bvalid one cycle.
- Read FSM R_IDLE/R_VALID. arready = ~rvalid | rready (skid-free, one outstanding).
  - On AR handshake: rdata = entry[araddr>>4], rlast=1, rvalid=1 next cycle.
  - rresp=SLVERR with rdata=0 if arlen!=0 or arsize!=4.
  - Back-to-back reads at full rate when rready held high.
- Read/write same entry in the same cycle: the read returns pre-write data. The write is visible to the next read.
- rdata is held stable while rvalid & ~rready.
- Entry index arithmetic is modulo DEPTH after the window check; offsets >= DEPTH*16 on cq_araddr never occur at CQ_ADDR_WIDTH=8.

Optional Feature:
- Macro NVME_CQ_RING_IRQ_EN.
- Defined: cq_irq pulses high for exactly one cycle, the cycle after a B handshake with bresp=OKAY where at least one beat wrote byte 14 (the phase byte).
- Undefined: cq_irq is tied to 0; no extra flops.

Decomposition:
- Shared package nvme_pkg holds:
  - address-map constants: OUTSTANDING, WRITE_BUF_BASE, READ_BUF_BASE, SQ_BASE, CQ_BASE;
  - AXI burst/resp enums;
  - typedef cq_entry_t (dw0, dw1, sqhd, sqid, cid, phase, status).
- One natural sub-module: nvme_cq_regfile. DEPTH x DATA_WIDTH, byte-write port plus a synchronous read port returning old-data on collision.

Test Plan:
- Single write: awaddr=0x20400, awlen=0, wdata phase=1 cid=3, wstrb=all ones -> bresp=OKAY with bid echoed. A subsequent read at araddr=0x00 returns the same 128 bits, rresp=0, rlast=1.
- Burst: awaddr=0x204F0, awlen=1 -> beat 0 writes entry 15, beat 1 (0x20500) is dropped, bresp=SLVERR. Entry 0 is unchanged.
- Strobe: wstrb=16'h4000 with wdata[119:112]=0x01 on entry 5 -> only the phase byte changes; the other bytes of entry 5 read back as 0.
- Collision: cq read and ns write to entry 2 in the same cycle -> the read returns old data (0). The next read returns the new data.
- Backpressure: rready=0 for 5 cycles -> rdata/rvalid held stable and arready=0. Bready delayed 3 cycles -> awready stays 0 until the B handshake.
- Reset: assert rst mid-burst after 1 of 4 beats -> bvalid=0, all entries read 0. With NVME_CQ_RING_IRQ_EN, a completed OKAY phase write yields a 1-cycle cq_irq; without the macro, cq_irq stays 0.
